// File: rtl/scope_capture_buffer.sv
// -----------------------------------------------------------------------------
// scope_capture_buffer
//
// Triggered capture buffer for the oscilloscope datapath. Samples of one
// selected ADC channel are recorded into a circular RAM. A level crossing
// (rising or falling) or an optional auto-trigger timeout ends the pre-trigger
// phase. The finished record is read back linearly and aligned to the trigger.
//
// Ports:
//   clk, Resetn          : clock, asynchronous active-low reset
//   sample_valid         : strobe qualifying sample_data / sample_ch
//   sample_data          : unsigned ADC code
//   sample_ch            : channel tag of the sample
//   arm, abort           : start a new capture / cancel and return to idle
//   cap_ch, trig_level,
//   trig_falling, pretrig,
//   auto_en, auto_timeout: capture configuration, latched on arm
//   rd_addr              : logical record index, 0 = oldest sample
//   rd_data              : record data, one cycle after rd_addr
//   busy                 : capture in progress (PRE / ARMED / POST)
//   done                 : capture complete
//   trig_forced          : completed capture was auto-triggered
// -----------------------------------------------------------------------------
module scope_capture_buffer #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3,
  parameter int ADDR_W = 8,
  parameter int AUTO_W = 16
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic              arm,
  input  logic              abort,
  input  logic [CH_W-1:0]   cap_ch,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              auto_en,
  input  logic [AUTO_W-1:0] auto_timeout,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              trig_forced
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  logic [CH_W-1:0]     cap_ch_q;
  logic [DATA_W-1:0]   trig_level_q;
  logic                trig_falling_q;
  logic [ADDR_W-1:0]   pretrig_q;
  logic                auto_en_q;
  logic [AUTO_W-1:0]   auto_timeout_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   pre_cnt_q;
  logic [ADDR_W-1:0]   post_left_q;
  logic [ADDR_W-1:0]   start_ptr_q;
  logic [AUTO_W-1:0]   auto_cnt_q;
  logic [DATA_W-1:0]   prev_q;
  logic                prev_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                trig_forced_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept_s;
  logic                pre_full_s;
  logic                edge_s;
  logic                force_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   rd_idx_s;

  // Sample qualification, trigger detection and RAM write enable
  always_comb begin
    accept_s   = sample_valid && (sample_ch == cap_ch_q);
    // Only true on PRE entry when pretrig is 0; otherwise PRE leaves on the
    // sample that fills the pre-trigger window.
    pre_full_s = (pre_cnt_q == pretrig_q);
    if (trig_falling_q) begin
      edge_s = prev_valid_q && (prev_q > trig_level_q) && (sample_data <= trig_level_q);
    end else begin
      edge_s = prev_valid_q && (prev_q < trig_level_q) && (sample_data >= trig_level_q);
    end
    force_s  = auto_en_q && (auto_timeout_q != {AUTO_W{1'b0}}) &&
               (auto_cnt_q == (auto_timeout_q - AUTO_W'(1)));
    rd_idx_s = start_ptr_q + rd_addr;
    wr_en_s  = 1'b0;
    if (accept_s && !abort) begin
      case (state_q)
        S_PRE:          wr_en_s = !pre_full_s;
        S_ARMED, S_POST: wr_en_s = 1'b1;
        default:        wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Capture control FSM with registered status outputs
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= S_IDLE;
      cap_ch_q       <= {CH_W{1'b0}};
      trig_level_q   <= {DATA_W{1'b0}};
      trig_falling_q <= 1'b0;
      pretrig_q      <= {ADDR_W{1'b0}};
      auto_en_q      <= 1'b0;
      auto_timeout_q <= {AUTO_W{1'b0}};
      wr_ptr_q       <= {ADDR_W{1'b0}};
      pre_cnt_q      <= {ADDR_W{1'b0}};
      post_left_q    <= {ADDR_W{1'b0}};
      start_ptr_q    <= {ADDR_W{1'b0}};
      auto_cnt_q     <= {AUTO_W{1'b0}};
      prev_q         <= {DATA_W{1'b0}};
      prev_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      trig_forced_q  <= 1'b0;
    end else if (abort) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      trig_forced_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            cap_ch_q       <= cap_ch;
            trig_level_q   <= trig_level;
            trig_falling_q <= trig_falling;
            pretrig_q      <= pretrig;
            auto_en_q      <= auto_en;
            auto_timeout_q <= auto_timeout;
            wr_ptr_q       <= {ADDR_W{1'b0}};
            pre_cnt_q      <= {ADDR_W{1'b0}};
            prev_valid_q   <= 1'b0;
            trig_forced_q  <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            state_q        <= S_PRE;
          end
        end
        S_PRE: begin
          if (pre_full_s) begin
            auto_cnt_q <= {AUTO_W{1'b0}};
            state_q    <= S_ARMED;
          end else if (accept_s) begin
            pre_cnt_q    <= pre_cnt_q + ADDR_W'(1);
            prev_q       <= sample_data;
            prev_valid_q <= 1'b1;
            if ((pre_cnt_q + ADDR_W'(1)) == pretrig_q) begin
              auto_cnt_q <= {AUTO_W{1'b0}};
              state_q    <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (accept_s) begin
            prev_q       <= sample_data;
            prev_valid_q <= 1'b1;
            auto_cnt_q   <= auto_cnt_q + AUTO_W'(1);
            if (edge_s || force_s) begin
              // Trigger sample sits at logical index pretrig of the record.
              start_ptr_q   <= wr_ptr_q - pretrig_q;
              post_left_q   <= {ADDR_W{1'b1}} - pretrig_q;
              trig_forced_q <= !edge_s;
              if (pretrig_q == {ADDR_W{1'b1}}) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (accept_s) begin
            post_left_q <= post_left_q - ADDR_W'(1);
            if (post_left_q == ADDR_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Capture RAM write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  // Registered, trigger-aligned read port
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= mem_q[rd_idx_s];
    end
  end

  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign trig_forced = trig_forced_q;

endmodule

// File: doc/scope_capture_buffer.md
Name: scope_capture_buffer

Overview:
- Parametrised triggered capture buffer for the oscilloscope datapath. Sits between the SPI ADC interface and the display/readout logic.
- Accepts a tagged stream of 12-bit samples from the multichannel ADC scan. Records only the selected channel into a circular RAM.
- Supports level/edge triggering with a programmable pre-trigger depth and an auto-trigger timeout.
- Presents the finished capture as a linear, trigger-aligned record over a registered read port.

Parameters:
- DATA_W, 12: sample width in bits.
- CH_W, 3: channel tag width (8 ADC channels).
- ADDR_W, 8: buffer address width; DEPTH = 2^ADDR_W = 256 samples.
- AUTO_W, 16: width of the auto-trigger timeout counter.

Ports:
- clk, in, 1: system clock (12 MHz domain).
- Resetn, in, 1: reset.
- sample_valid, in, 1: one-cycle strobe; sample_data/sample_ch are valid.
- sample_data, in, DATA_W: unsigned ADC code.
- sample_ch, in, CH_W: channel tag of the sample.
- arm, in, 1: pulse; start a new capture.
- abort, in, 1: pulse; cancel the capture and return to idle.
- cap_ch, in, CH_W: channel to capture and trigger on; latched at arm.
- trig_level, in, DATA_W: trigger threshold; latched at arm.
- trig_falling, in, 1: 0 selects rising edge, 1 selects falling edge; latched at arm.
- pretrig, in, ADDR_W: number of samples kept before the trigger; latched at arm.
- auto_en, in, 1: enables the forced trigger; latched at arm.
- auto_timeout, in, AUTO_W: number of armed samples before a forced trigger; latched at arm.
- rd_addr, in, ADDR_W: logical index; 0 is the oldest sample of the record.
- rd_data, out, DATA_W: buffer data; valid one cycle after rd_addr.
- busy, out, 1: high in PRE, ARMED and POST.
- done, out, 1: high in DONE.
- trig_forced, out, 1: the completed capture was auto-triggered.

Behaviour:
- Reset is asynchronous and active-low on Resetn; one clock, clk.
- Reset values:
  - rd_data, busy, done and trig_forced are 0.
  - The state is IDLE; all pointers and counters are 0.
  - RAM contents are undefined.
- "Accepted sample" means sample_valid=1 and sample_ch equals the latched cap_ch. Other samples are ignored in every state.
- Every accepted sample in PRE, ARMED or POST is written to RAM[wr_ptr], then wr_ptr increments modulo DEPTH.
- States:
  - IDLE: wait. On arm: latch the configuration, set wr_ptr=0, pre_cnt=0, prev_valid=0, trig_forced=0 → PRE.
  - PRE: each accepted sample increments pre_cnt. When pre_cnt reaches pretrig → ARMED. If pretrig=0, go to ARMED on the cycle after arm with no sample written. Triggers are ignored in PRE.
  - ARMED: each accepted sample is written. A trigger occurs on an accepted sample when prev_valid=1 and either:
    - rising: prev < trig_level and cur >= trig_level;
    - falling: prev > trig_level and cur <= trig_level.
    On trigger: start_ptr = (wr_ptr - pretrig) mod DEPTH, using wr_ptr before the increment; post_left = DEPTH-1-pretrig → POST. If post_left = 0, go directly to DONE.
  - POST: each accepted sample decrements post_left. The sample that takes post_left to 0 is written and the state → DONE.
  - DONE: hold the data. arm restarts as in IDLE.
- prev register: updated with cur on every accepted sample in PRE and ARMED; prev_valid is set on the first such sample.
- Auto-trigger (auto_en=1):
  - auto_cnt clears on entry to ARMED and counts accepted samples in ARMED.
  - When an accepted sample arrives with auto_cnt = auto_timeout-1, that sample is the trigger and trig_forced is set to 1.
  - auto_timeout=0 disables the forced trigger.
  - A real edge on the same sample takes priority; trig_forced stays 0.
- abort returns to IDLE from any state. done and trig_forced clear; RAM is not cleared.
- abort and arm in the same cycle: abort wins.
- arm in PRE, ARMED or POST is ignored.
- Read port:
  - Synchronous read: rd_data <= RAM[(start_ptr + rd_addr) mod DEPTH] every cycle, in any state.
  - The result is meaningful only in DONE.
  - Logical index pretrig is the trigger sample.
- RAM is a single write port plus a single read port; it must infer block RAM.

Test Plan:
- Rising trigger: pretrig=4, cap_ch=2, level=0x800; channel-2 ramp 0x700, 0x780, …, step 0x80. Other channels are interleaved → record indices 0..3 = 0x700..0x880? No: trigger is at 0x800 (the 3rd sample). PRE consumes 4 samples first, so the trigger is at 0x900-level crossing only if rising again. Use a sawtooth 0x000→0xF00, step 0x100, repeated. Expect index 4 = 0x800, index 3 = 0x700, index 255 = 255th continuation; done=1 and busy=0 after 251 post samples.
- Falling edge: level=0x400, sequence 0x600, 0x500, 0x400 → trigger on 0x400. A value equal to the level preceded by a value equal to the level does not trigger.
- Auto: auto_en=1, auto_timeout=10, constant 0x123 → trigger on the 10th armed sample, trig_forced=1, all 256 reads = 0x123.
- Boundaries:
  - pretrig=255 → DONE on the trigger cycle.
  - pretrig=0 → index 0 = trigger sample.
  - Check wr_ptr wrap with start_ptr crossing 255→0.
- abort mid-POST → busy=0, done=0 next cycle. arm+abort same cycle → IDLE.
- Async reset asserted in ARMED → all outputs 0 immediately, without a clock edge.
